// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - renderer and VGA pin bundle of the raster timing generator
interface vga_timing_if #(
    parameter int RGB_W = 4
);
    logic                 pix_req;
    logic [9:0]           pix_x;
    logic [9:0]           pix_y;
    logic [3*RGB_W-1:0]   rgb_in;
    logic                 frame_end;
    logic                 vga_hs;
    logic                 vga_vs;
    logic [RGB_W-1:0]     vga_r;
    logic [RGB_W-1:0]     vga_g;
    logic [RGB_W-1:0]     vga_b;

    modport master (
        output pix_req, pix_x, pix_y, frame_end, vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  rgb_in
    );

    modport slave (
        input  pix_req, pix_x, pix_y, frame_end, vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 800x600@60 raster timing with pin-aligned colour and sync pipeline
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int RGB_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_if.master     vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap;
    logic        active;
    logic        hs_raw;
    logic        vs_raw;
    logic        fe_raw;

    logic        hs_s1, vs_s1;
    logic        de_d, hs_s2, vs_s2;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_raw = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_raw = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        fe_raw = (h_cnt == 11'd0) && (v_cnt == V_VIS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? 11'd0 : h_cnt + 11'd1;
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    // Three register stages: coordinates out, renderer latency, pin alignment.
    // Sync travels through the same depth so it lands on the same edge as colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga.pix_req   <= 1'b0;
            vga.pix_x     <= '0;
            vga.pix_y     <= '0;
            vga.frame_end <= 1'b0;
            hs_s1         <= 1'b0;
            vs_s1         <= 1'b0;
            de_d          <= 1'b0;
            hs_s2         <= 1'b0;
            vs_s2         <= 1'b0;
            vga.vga_r     <= '0;
            vga.vga_g     <= '0;
            vga.vga_b     <= '0;
            vga.vga_hs    <= 1'b0;
            vga.vga_vs    <= 1'b0;
        end else begin
            vga.pix_req   <= active;
            vga.pix_x     <= active ? h_cnt[9:0] : 10'd0;
            vga.pix_y     <= active ? v_cnt : 10'd0;
            vga.frame_end <= fe_raw;
            hs_s1         <= hs_raw;
            vs_s1         <= vs_raw;

            de_d          <= vga.pix_req;
            hs_s2         <= hs_s1;
            vs_s2         <= vs_s1;

            vga.vga_r     <= de_d ? vga.rgb_in[3*RGB_W-1 -: RGB_W] : '0;
            vga.vga_g     <= de_d ? vga.rgb_in[2*RGB_W-1 -: RGB_W] : '0;
            vga.vga_b     <= de_d ? vga.rgb_in[RGB_W-1 -: RGB_W]   : '0;
            vga.vga_hs    <= hs_s2;
            vga.vga_vs    <= vs_s2;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed vector bench for vga_timing at full and reduced raster size
module tb_vga_timing;
    typedef struct {
        int          cyc;
        logic [35:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [11:0] next_rgb = 12'hFFF;

    always #5 clk = ~clk;

    vga_timing_if #(.RGB_W(4)) vif ();
    vga_timing_if #(.RGB_W(4)) sif ();

    vga_timing dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    // Reduced raster: H_TOTAL=25 (hsync h=18..21), V_TOTAL=11 (vsync v=7..8), frame=275 clks
    vga_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .RGB_W(4)
    ) dut_s (
        .clk (clk),
        .rst (rst_s),
        .vga (sif)
    );

    // Renderer: returns a colour one clk after each coordinate, FFF in blanking
    initial begin
        forever begin
            @(negedge clk);
            vif.rgb_in = next_rgb;
            next_rgb   = vif.pix_req ? {vif.pix_x[3:0], vif.pix_y[3:0], 4'hA} : 12'hFFF;
        end
    end

    function automatic logic [35:0] mk(logic req, logic [9:0] x, logic [9:0] y,
                                       logic hs, logic vs, logic fe, logic [11:0] rgb);
        return {req, x, y, hs, vs, fe, rgb};
    endfunction

    function automatic logic [35:0] obs_d();
        return {vif.pix_req, vif.pix_x, vif.pix_y, vif.vga_hs, vif.vga_vs, vif.frame_end,
                vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    function automatic logic [35:0] obs_s();
        return {sif.pix_req, sif.pix_x, sif.pix_y, sif.vga_hs, sif.vga_vs, sif.frame_end,
                sif.vga_r, sif.vga_g, sif.vga_b};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (req,x,y,hs,vs,fe,rgb)", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    vec_t dt[$];
    vec_t st[$];

    initial begin
        int req_cnt, xerr, hs_cnt, vferr, fe_cnt, vs_cnt, hs_rise;
        logic prev_hs;

        // Full-size raster, first line and start of second (cycle n samples pixel n-1, pins show n-3)
        dt.push_back('{1,    mk(1, 0,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{2,    mk(1, 1,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{3,    mk(1, 2,   0, 0, 0, 0, 12'h00A)});
        dt.push_back('{4,    mk(1, 3,   0, 0, 0, 0, 12'h10A)});
        dt.push_back('{800,  mk(1, 799, 0, 0, 0, 0, 12'hD0A)});
        dt.push_back('{801,  mk(0, 0,   0, 0, 0, 0, 12'hE0A)});
        dt.push_back('{802,  mk(0, 0,   0, 0, 0, 0, 12'hF0A)});
        dt.push_back('{803,  mk(0, 0,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{842,  mk(0, 0,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{843,  mk(0, 0,   0, 1, 0, 0, 12'h000)});
        dt.push_back('{970,  mk(0, 0,   0, 1, 0, 0, 12'h000)});
        dt.push_back('{971,  mk(0, 0,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{1056, mk(0, 0,   0, 0, 0, 0, 12'h000)});
        dt.push_back('{1057, mk(1, 0,   1, 0, 0, 0, 12'h000)});
        dt.push_back('{1059, mk(1, 2,   1, 0, 0, 0, 12'h01A)});
        dt.push_back('{1080, mk(1, 23,  1, 0, 0, 0, 12'h51A)});

        // Reduced raster with rgb_in tied to FFF
        st.push_back('{1,   mk(1, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{3,   mk(1, 2,  0, 0, 0, 0, 12'hFFF)});
        st.push_back('{16,  mk(1, 15, 0, 0, 0, 0, 12'hFFF)});
        st.push_back('{17,  mk(0, 0,  0, 0, 0, 0, 12'hFFF)});
        st.push_back('{19,  mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{20,  mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{21,  mk(0, 0,  0, 1, 0, 0, 12'h000)});
        st.push_back('{24,  mk(0, 0,  0, 1, 0, 0, 12'h000)});
        st.push_back('{25,  mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{26,  mk(1, 0,  1, 0, 0, 0, 12'h000)});
        st.push_back('{28,  mk(1, 2,  1, 0, 0, 0, 12'hFFF)});
        st.push_back('{150, mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{151, mk(0, 0,  0, 0, 0, 1, 12'h000)});
        st.push_back('{152, mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{177, mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{178, mk(0, 0,  0, 0, 1, 0, 12'h000)});
        st.push_back('{227, mk(0, 0,  0, 0, 1, 0, 12'h000)});
        st.push_back('{228, mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{275, mk(0, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{276, mk(1, 0,  0, 0, 0, 0, 12'h000)});
        st.push_back('{278, mk(1, 2,  0, 0, 0, 0, 12'hFFF)});
        st.push_back('{426, mk(0, 0,  0, 0, 0, 1, 12'h000)});

        rst        = 1'b0;
        rst_s      = 1'b0;
        sif.rgb_in = 12'hFFF;
        vif.rgb_in = 12'hFFF;
        repeat (5) @(posedge clk);
        #1;
        check("reset_full", obs_d(), '0);
        check("reset_small", obs_s(), '0);

        @(negedge clk);
        rst = 1'b1;
        req_cnt = 0; xerr = 0; hs_cnt = 0; vferr = 0;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk);
            #1;
            foreach (dt[i]) if (dt[i].cyc == n) check($sformatf("full_cyc%0d", n), obs_d(), dt[i].exp);
            if (n <= 1056 && vif.pix_req) begin
                req_cnt++;
                if (vif.pix_x != 10'(n - 1) || vif.pix_y != 10'd0) xerr++;
            end
            if (n >= 3 && n <= 1058 && vif.vga_hs) hs_cnt++;
            if (vif.vga_vs || vif.frame_end) vferr++;
        end
        check_int("line_pix_req_clks", req_cnt, 800);
        check_int("line_pix_x_seq_errors", xerr, 0);
        check_int("line_hs_clks", hs_cnt, 128);
        check_int("line_vs_fe_stray", vferr, 0);

        rst = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        fe_cnt = 0; vs_cnt = 0; hs_rise = 0; prev_hs = 1'b0;
        for (int n = 1; n <= 830; n++) begin
            @(posedge clk);
            #1;
            foreach (st[i]) if (st[i].cyc == n) check($sformatf("small_cyc%0d", n), obs_s(), st[i].exp);
            if (n <= 825) begin
                fe_cnt += int'(sif.frame_end);
                vs_cnt += int'(sif.vga_vs);
            end
            if (n >= 178 && n <= 452 && sif.vga_hs && !prev_hs) hs_rise++;
            prev_hs = sif.vga_hs;
        end
        check_int("frame_end_pulses_3frames", fe_cnt, 3);
        check_int("vs_clks_3frames", vs_cnt, 150);
        check_int("lines_per_vs_period", hs_rise, 11);

        // Mid-frame reset at counters (8,3), then restart from (0,0)
        rst_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        for (int n = 1; n <= 83; n++) @(posedge clk);
        #1;
        check("midframe_before", obs_s(), mk(1, 7, 3, 0, 0, 0, 12'hFFF));
        #1;
        rst_s = 1'b0;
        #1;
        check("midframe_async_clear", obs_s(), '0);
        repeat (2) @(posedge clk);
        #1;
        check("midframe_held", obs_s(), '0);
        @(negedge clk);
        rst_s = 1'b1;
        @(posedge clk);
        #1;
        check("restart_first", obs_s(), mk(1, 0, 0, 0, 0, 0, 12'h000));
        repeat (2) @(posedge clk);
        #1;
        check("restart_colour", obs_s(), mk(1, 2, 0, 0, 0, 0, 12'hFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
